scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3, select width; legal range 1..5; output width is 2**SEL_W.
REQ-002 Parameter SCAN_DIV, default 4, clock cycles per scan step; legal range >= 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 G  input  1  enable, active-high.
REQ-006 G2A  input  1  enable, active-low.
REQ-007 G2B  input  1  enable, active-low.
REQ-008 mode  input  1  0 = direct decode of sel, 1 = auto-scan.
REQ-009 sel  input  SEL_W  select index used in direct mode.
REQ-010 Y  output  2**SEL_W  registered decoded lines, active-low, at most one bit low.
REQ-011 idx  output  SEL_W  registered index currently driven low on Y.
REQ-012 wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 en SHALL be G & ~G2A & ~G2B, sampled each cycle.
REQ-014 FSM SHALL have states IDLE, DIRECT, SCAN; next state = IDLE if !en, else DIRECT if mode=0, else SCAN.
REQ-015 Y SHALL be registered: value for state/inputs sampled at edge k appears after edge k (1-cycle latency).
REQ-016 In IDLE, Y SHALL be all ones; idx, prescaler and wrap SHALL hold (wrap = 0).
REQ-017 In DIRECT, idx SHALL load sel every cycle and Y SHALL have only bit sel low.
REQ-018 In SCAN, prescaler SHALL count 0..SCAN_DIV-1; at terminal count it SHALL return to 0 and idx SHALL increment by 1.
REQ-019 idx SHALL wrap from 2**SEL_W-1 to 0; wrap SHALL be 1 in the cycle idx becomes 0 via that wrap, else 0.
REQ-020 In SCAN, Y SHALL have only bit idx low.
REQ-021 Entry into SCAN from DIRECT or from reset-IDLE SHALL load idx = 0, prescaler = 0, wrap = 0.
REQ-022 Entry into SCAN from IDLE that was entered from SCAN SHALL resume idx and prescaler unchanged (freeze/resume).
REQ-023 SCAN_DIV = 1 SHALL advance idx every cycle in SCAN.
REQ-024 SCAN to DIRECT SHALL show sel on Y on the next cycle, with no intermediate value.
REQ-025 Enable drop and mode change in the same cycle SHALL go to IDLE; the mode change takes effect on re-enable.

Reset
REQ-026 rst_n = 0 at a rising edge SHALL set Y = all ones, idx = 0, prescaler = 0, wrap = 0, state = IDLE, and clear the resume flag.
REQ-027 Reset SHALL override all other inputs, including mid-scan; the first edge with rst_n = 1 SHALL evaluate REQ-014 normally.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and a function returning an active-low one-hot vector for an index.
REQ-029 The prescaler SHALL be one sub-module, scan_prescaler, with SCAN_DIV parameter, count-enable, clear, and terminal-count output.
REQ-030 The parameter legality of REQ-001/REQ-002 SHALL be checked at elaboration.

Verification
REQ-031 Reset, then G=1, G2A=0, G2B=0, mode=0, sel=0..7 at 50 ns steps -> Y = 8'hFE, FD, FB, F7, EF, DF, BF, 7F, each one cycle after sel changes.
REQ-032 Enables (G,G2A,G2B) = (0,0,0), (1,1,0), (1,0,1) with sel=5 -> Y = 8'hFF, idx unchanged.
REQ-033 mode=1, SCAN_DIV=4, enabled for 40 cycles -> idx steps 0..7 every 4 cycles; wrap high exactly once, at cycle 32 after entry.
REQ-034 In SCAN at idx=3, deassert G for 10 cycles, then reassert -> Y = FF during gap; scan resumes at idx=3, same prescaler phase.
REQ-035 In SCAN at idx=6, pulse rst_n low one cycle -> next Y = FF, idx=0; the scan then restarts from idx 0.
REQ-036 SEL_W=2, SCAN_DIV=1, mode=1 -> Y cycles E,D,B,7 every clock; wrap every 4th cycle.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder.
// Contents:
//   MAX_SEL_W / MAX_Y - widest supported select and decoded-output widths
//   state_e           - FSM state encoding
//   onehot_n()        - active-low one-hot vector with only bit i low
package scan_decoder_pkg;

    localparam int unsigned MAX_SEL_W = 5;
    localparam int unsigned MAX_Y     = 2 ** MAX_SEL_W;

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    // Returns a MAX_Y-wide vector; callers keep only the low 2**SEL_W bits.
    function automatic logic [MAX_Y-1:0] onehot_n(input logic [MAX_SEL_W-1:0] i);
        logic [MAX_Y-1:0] v;
        v    = '1;
        v[i] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder.
// Signals:
//   G, G2A, G2B - enables (active-high, active-low, active-low)
//   mode        - 0 = direct decode of sel, 1 = auto-scan
//   sel         - direct-mode select index
//   Y           - registered active-low decoded lines
//   idx         - registered index currently driven low on Y
//   wrap        - one-cycle pulse when the scan index wraps to 0
// Modports: master drives the controls, slave is the decoder.
interface scan_decoder_if #(
    parameter int unsigned SEL_W = 3
);
    logic                  G;
    logic                  G2A;
    logic                  G2B;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [2**SEL_W-1:0]   Y;
    logic [SEL_W-1:0]      idx;
    logic                  wrap;

    modport master (
        output G, G2A, G2B, mode, sel,
        input  Y, idx, wrap
    );

    modport slave (
        input  G, G2A, G2B, mode, sel,
        output Y, idx, wrap
    );

endinterface

// File: rtl/scan_decoder_prescaler.sv
// Scan-step prescaler: counts 0..SCAN_DIV-1 while enabled.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   en_i       - count enable
//   clr_i      - synchronous clear (wins over en_i)
//   tc_o       - high while the count sits at SCAN_DIV-1
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);
    // Keep at least one bit so SCAN_DIV = 1 still elaborates.
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered 1-of-2**SEL_W active-low decoder with direct and auto-scan modes.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - scan_decoder_if slave (enables, mode, sel in; Y, idx, wrap out)
// Scan mode steps idx every SCAN_DIV cycles; dropping the enable out of scan
// freezes idx and prescaler, and re-enabling scan resumes from that point.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    scan_decoder_if.slave bus
);
    localparam int unsigned      NUM_Y   = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
        $error("scan_decoder: SEL_W must be in 1..5");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("scan_decoder: SCAN_DIV must be >= 1");
    end

    state_e           state_q, state_d;
    logic [NUM_Y-1:0] y_q, y_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             resume_q, resume_d;  // idle was entered from scan
    logic             en;
    logic             pre_en, pre_clr, pre_tc;
    logic [MAX_Y-1:0] y_full;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pre_en),
        .clr_i (pre_clr),
        .tc_o  (pre_tc)
    );

    always_comb begin
        en = bus.G & ~bus.G2A & ~bus.G2B;

        if (!en) begin
            state_d = StIdle;
        end else if (bus.mode) begin
            state_d = StScan;
        end else begin
            state_d = StDirect;
        end

        idx_d    = idx_q;
        wrap_d   = 1'b0;
        resume_d = resume_q;
        pre_en   = 1'b0;
        pre_clr  = 1'b0;
        y_full   = '1;

        unique case (state_d)
            StIdle: begin
                if (state_q == StScan) begin
                    resume_d = 1'b1;
                end
            end
            StDirect: begin
                idx_d    = bus.sel;
                resume_d = 1'b0;
                pre_clr  = 1'b1;
                y_full   = onehot_n(MAX_SEL_W'(idx_d));
            end
            StScan: begin
                resume_d = 1'b0;
                // Only scan-to-scan edges advance; the entry edge either
                // restarts from 0 or holds the frozen position.
                if (state_q == StScan) begin
                    pre_en = 1'b1;
                    if (pre_tc) begin
                        idx_d  = idx_q + 1'b1;
                        wrap_d = (idx_q == IDX_MAX);
                    end
                end else if (!resume_q) begin
                    idx_d   = '0;
                    pre_clr = 1'b1;
                end
                y_full = onehot_n(MAX_SEL_W'(idx_d));
            end
            default: begin
                y_full = '1;
            end
        endcase

        y_d = y_full[NUM_Y-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            y_q      <= '1;
            idx_q    <= '0;
            wrap_q   <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            wrap_q   <= wrap_d;
            resume_q <= resume_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: an 8-line instance (SEL_W=3,
// SCAN_DIV=4) for direct/enable/scan/freeze/reset behaviour and a 4-line
// instance (SEL_W=2, SCAN_DIV=1) for single-cycle scanning.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    scan_decoder_if #(.SEL_W(3)) bus ();
    scan_decoder_if #(.SEL_W(2)) bus2 ();

    scan_decoder #(
        .SEL_W    (3),
        .SCAN_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    scan_decoder #(
        .SEL_W    (2),
        .SCAN_DIV (1)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        bit         unit;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wrap_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] y8(input int i);
        logic [7:0] v;
        v = 8'd1 << i;
        return ~v;
    endfunction

    function automatic logic [7:0] y4(input int i);
        logic [3:0] v;
        v = 4'd1 << i;
        return {4'h0, ~v};
    endfunction

    // Push the expectation for the inputs now applied, clock once, then pop
    // and compare against whichever instance the entry names.
    task automatic cycle(input string tag, input bit unit, input logic [7:0] y,
                         input int idx, input logic wrap);
        exp_t e;
        e.unit = unit;
        e.y    = y;
        e.idx  = 3'(idx);
        e.wrap = wrap;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (!e.unit) begin
            check({tag, ".Y"},    32'(bus.Y),    32'(e.y));
            check({tag, ".idx"},  32'(bus.idx),  32'(e.idx));
            check({tag, ".wrap"}, 32'(bus.wrap), 32'(e.wrap));
        end else begin
            check({tag, ".Y"},    32'(bus2.Y),    32'(e.y[3:0]));
            check({tag, ".idx"},  32'(bus2.idx),  32'(e.idx[1:0]));
            check({tag, ".wrap"}, 32'(bus2.wrap), 32'(e.wrap));
        end
    endtask

    // k counts scan-to-scan edges since a fresh entry; idx steps every 4.
    task automatic scan_run(input string tag, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            cycle(tag, 1'b0, y8((k / 4) % 8), (k / 4) % 8, (k > 0) && (k % 32 == 0));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.G     = 1'b0;
        bus.G2A   = 1'b0;
        bus.G2B   = 1'b0;
        bus.mode  = 1'b0;
        bus.sel   = '0;
        bus2.G    = 1'b0;
        bus2.G2A  = 1'b0;
        bus2.G2B  = 1'b0;
        bus2.mode = 1'b0;
        bus2.sel  = '0;

        cycle("reset", 1'b0, 8'hFF, 0, 1'b0);
        cycle("reset", 1'b0, 8'hFF, 0, 1'b0);
        cycle("reset2", 1'b1, 8'h0F, 0, 1'b0);

        // Direct decode of every select value.
        rst_n = 1'b1;
        bus.G = 1'b1;
        for (int s = 0; s < 8; s++) begin
            bus.sel = 3'(s);
            for (int c = 0; c < 5; c++) begin
                cycle("direct", 1'b0, y8(s), s, 1'b0);
            end
        end

        // Each disabling enable combination blanks Y and holds idx at 7.
        bus.sel = 3'd5;
        bus.G = 1'b0; bus.G2A = 1'b0; bus.G2B = 1'b0;
        cycle("en000", 1'b0, 8'hFF, 7, 1'b0);
        cycle("en000", 1'b0, 8'hFF, 7, 1'b0);
        bus.G = 1'b1; bus.G2A = 1'b1; bus.G2B = 1'b0;
        cycle("en110", 1'b0, 8'hFF, 7, 1'b0);
        cycle("en110", 1'b0, 8'hFF, 7, 1'b0);
        bus.G = 1'b1; bus.G2A = 1'b0; bus.G2B = 1'b1;
        cycle("en101", 1'b0, 8'hFF, 7, 1'b0);
        cycle("en101", 1'b0, 8'hFF, 7, 1'b0);

        // Full 40-cycle scan entered from direct; wrap exactly once at 32.
        bus.G2B = 1'b0;
        bus.sel = 3'd2;
        cycle("pre_scan", 1'b0, 8'hFB, 2, 1'b0);
        bus.mode  = 1'b1;
        wrap_seen = 0;
        for (int k = 0; k < 40; k++) begin
            cycle("scan40", 1'b0, y8((k / 4) % 8), (k / 4) % 8, (k > 0) && (k % 32 == 0));
            if (bus.wrap === 1'b1) wrap_seen++;
        end
        check("wrap_count", 32'(wrap_seen), 32'd1);

        // Freeze at idx 3 for 10 cycles, then resume at the same phase.
        bus.mode = 1'b0;
        bus.sel  = 3'd1;
        cycle("pre_freeze", 1'b0, 8'hFD, 1, 1'b0);
        bus.mode = 1'b1;
        scan_run("scan_a", 0, 13);
        bus.G = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle("frozen", 1'b0, 8'hFF, 3, 1'b0);
        end
        bus.G = 1'b1;
        scan_run("resume", 13, 25);

        // Reset pulse mid-scan at idx 6, then restart from 0.
        rst_n = 1'b0;
        cycle("mid_rst", 1'b0, 8'hFF, 0, 1'b0);
        rst_n = 1'b1;
        scan_run("restart", 0, 7);

        // Scan straight to direct: sel appears on the next cycle.
        bus.mode = 1'b0;
        bus.sel  = 3'd6;
        cycle("scan2dir", 1'b0, 8'hBF, 6, 1'b0);

        // Enable drop with a simultaneous mode change goes idle first.
        bus.mode = 1'b1;
        scan_run("scan_b", 0, 5);
        bus.G    = 1'b0;
        bus.mode = 1'b0;
        cycle("drop_mode", 1'b0, 8'hFF, 1, 1'b0);
        cycle("drop_mode", 1'b0, 8'hFF, 1, 1'b0);
        bus.G = 1'b1;
        cycle("reen_dir", 1'b0, 8'hBF, 6, 1'b0);
        bus.G = 1'b0;

        // Narrow instance scanning every clock: E, D, B, 7, wrap every 4th.
        bus2.G    = 1'b1;
        bus2.mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle("scan_div1", 1'b1, y4(k % 4), k % 4, (k > 0) && (k % 4 == 0));
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
